mem_latency_shim: RTL and testbench
===================================

MEM_LATENCY_SHIM -- requirements
Module: mem_latency_shim

Interface
REQ-001 The block SHALL have parameter DELAY, default 0, meaning extra cycles inserted before each CPU response (0..255).
REQ-002 The block SHALL have parameter TIMEOUT, default 1024, meaning maximum cycles to wait for mem_resp (2..65535).
REQ-003 The block SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have ports cpu_addr  input  32, cpu_rmask  input  4, cpu_wmask  input  4, cpu_wdata  input  32, for the upstream CPU request.
REQ-006 The block SHALL have ports cpu_rdata  output  32 and cpu_resp  output  1, for the upstream CPU response.
REQ-007 The block SHALL have ports mem_addr  output  32, mem_rmask  output  4, mem_wmask  output  4, mem_wdata  output  32, for the downstream memory request.
REQ-008 The block SHALL have ports mem_rdata  input  32 and mem_resp  input  1, for the downstream memory response.
REQ-009 The block SHALL have port error  output  5  sticky protocol-error vector: [0] overlap, [1] rw_both, [2] misalign, [3] timeout, [4] spurious.

Function
REQ-010 A request SHALL be any cycle with cpu_rmask != 0 or cpu_wmask != 0; masks are single-cycle pulses.
REQ-011 The FSM SHALL have states IDLE, ISSUE, WAIT, DELAY, RESP.
REQ-012 In IDLE, a request SHALL register addr, masks and wdata and move to ISSUE.
REQ-013 In ISSUE, the registered request SHALL drive mem_* for exactly one cycle; then the FSM SHALL move to WAIT.
REQ-014 mem_rmask and mem_wmask SHALL be 0 in every state other than ISSUE; mem_addr and mem_wdata hold the last registered values.
REQ-015 In WAIT, mem_resp SHALL capture mem_rdata; the FSM SHALL then move to DELAY if DELAY>0, else to RESP.
REQ-016 DELAY SHALL count exactly DELAY cycles before entering RESP.
REQ-017 In RESP, cpu_resp SHALL be 1 for exactly one cycle with cpu_rdata = captured data; the FSM SHALL then return to IDLE.
REQ-018 End-to-end, a request at cycle N with mem_resp at cycle M SHALL yield cpu_resp at cycle M+1+DELAY; mem request SHALL appear at N+1.
REQ-019 cpu_rdata SHALL hold its last value outside RESP; write responses return the captured mem_rdata unchanged.
REQ-020 A request while not IDLE SHALL be dropped (not forwarded) and set error[0].
REQ-021 A request with both rmask and wmask nonzero SHALL set error[1] and still be forwarded unchanged.
REQ-022 A request with cpu_addr[1:0] != 0 SHALL set error[2] and still be forwarded unchanged.
REQ-023 If WAIT lasts TIMEOUT cycles without mem_resp, the block SHALL set error[3], return to IDLE, and issue no cpu_resp.
REQ-024 mem_resp in any state other than WAIT SHALL set error[4] and be otherwise ignored.
REQ-025 A request in the same cycle cpu_resp is asserted SHALL be treated as overlap (error[0]); a request is accepted only in IDLE.
REQ-026 error bits SHALL be sticky until reset; multiple bits MAY set in one cycle.
REQ-027 The timeout and delay counters SHALL saturate and never wrap.

Reset
REQ-028 While rst=1, the FSM SHALL go to IDLE; cpu_resp, mem_rmask, mem_wmask and error SHALL be 0; cpu_rdata, mem_addr and mem_wdata SHALL be 32'h0.
REQ-029 Reset mid-transaction SHALL abandon it silently: no cpu_resp, no error set; a late mem_resp after reset SHALL set error[4].

Structure
REQ-030 Package mem_shim_pkg SHALL hold the state enum and the error-bit index localparams.
REQ-031 One sub-module, shim_counter, SHALL implement a loadable saturating 16-bit down-counter with a zero flag, instantiated twice (delay, timeout).

Verification
REQ-032 Read with DELAY=0: rmask=4'hF at addr 32'h1000 at cycle 10, mem_resp at 13 with rdata 32'hDEADBEEF -> mem_rmask=4'hF at 11 only; cpu_resp at 14 with 32'hDEADBEEF; error=0.
REQ-033 Write with DELAY=3: wmask=4'h3, wdata 32'h0000ABCD at 32'h2004, mem_resp at cycle 20 -> mem_wmask=4'h3 for one cycle; cpu_resp at cycle 24.
REQ-034 Overlap: a second rmask request while in WAIT -> not forwarded; error=5'b00001; first transaction completes normally.
REQ-035 Timeout with TIMEOUT=8: issue a read and never assert mem_resp -> error[3]=1 at 8 cycles after entering WAIT; FSM in IDLE; no cpu_resp; next request is accepted.
REQ-036 Misaligned plus both masks: addr 32'h1002 with rmask=4'h1 and wmask=4'h1 -> error=5'b00110; request forwarded unchanged.
REQ-037 Reset mid-WAIT, then mem_resp 2 cycles after reset deasserts -> no cpu_resp; error=5'b10000.

Source files
------------

// File: rtl/mem_latency_shim_pkg.sv
// Shared types for the memory latency shim: FSM state encoding and
// bit positions within the sticky protocol-error vector.
package mem_shim_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DELAY,
        S_RESP
    } state_t;

    localparam int ERR_W        = 5;
    localparam int ERR_OVERLAP  = 0;
    localparam int ERR_RW_BOTH  = 1;
    localparam int ERR_MISALIGN = 2;
    localparam int ERR_TIMEOUT  = 3;
    localparam int ERR_SPURIOUS = 4;

endpackage

// File: rtl/mem_latency_shim_counter.sv
// Loadable 16-bit down-counter that sticks at zero instead of wrapping;
// used for both the response-delay and the memory-timeout countdowns.
module shim_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        en,
    input  logic [15:0] load_val,
    output logic        zero
);

    logic [15:0] count;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values and simulation matches the synthesized registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && count != '0) begin
            count <= count - 16'd1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/mem_latency_shim.sv
// Single-outstanding CPU-to-memory shim that adds DELAY cycles to every
// response, times out silent memories and records protocol errors.
module mem_latency_shim
    import mem_shim_pkg::*;
#(
    parameter int unsigned DELAY   = 0,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      cpu_addr,
    input  logic [3:0]       cpu_rmask,
    input  logic [3:0]       cpu_wmask,
    input  logic [31:0]      cpu_wdata,
    output logic [31:0]      cpu_rdata,
    output logic             cpu_resp,
    output logic [31:0]      mem_addr,
    output logic [3:0]       mem_rmask,
    output logic [3:0]       mem_wmask,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata,
    input  logic             mem_resp,
    output logic [ERR_W-1:0] error
);

    // Counters are preloaded with N-1 so the state they guard lasts exactly N cycles.
    localparam logic [15:0] DLY_LOAD = (DELAY == 0) ? 16'd0 : 16'(DELAY - 1);
    localparam logic [15:0] TO_LOAD  = 16'(TIMEOUT - 1);

    state_t      state;
    logic [31:0] rdata_q;
    logic        is_req;
    logic        dly_zero;
    logic        to_zero;

    assign is_req = (cpu_rmask != '0) || (cpu_wmask != '0);

    shim_counter u_delay_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (state == S_WAIT && mem_resp),
        .en       (state == S_DELAY),
        .load_val (DLY_LOAD),
        .zero     (dly_zero)
    );

    shim_counter u_timeout_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (state == S_ISSUE),
        .en       (state == S_WAIT),
        .load_val (TO_LOAD),
        .zero     (to_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cpu_resp  <= 1'b0;
            cpu_rdata <= '0;
            mem_addr  <= '0;
            mem_rmask <= '0;
            mem_wmask <= '0;
            mem_wdata <= '0;
            rdata_q   <= '0;
            error     <= '0;
        end else begin
            if (is_req && state != S_IDLE)
                error[ERR_OVERLAP] <= 1'b1;
            if (cpu_rmask != '0 && cpu_wmask != '0)
                error[ERR_RW_BOTH] <= 1'b1;
            if (is_req && cpu_addr[1:0] != 2'b00)
                error[ERR_MISALIGN] <= 1'b1;
            if (mem_resp && state != S_WAIT)
                error[ERR_SPURIOUS] <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (is_req) begin
                        mem_addr  <= cpu_addr;
                        mem_rmask <= cpu_rmask;
                        mem_wmask <= cpu_wmask;
                        mem_wdata <= cpu_wdata;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    mem_rmask <= '0;
                    mem_wmask <= '0;
                    state     <= S_WAIT;
                end
                S_WAIT: begin
                    // A response in the final WAIT cycle still wins over the timeout.
                    if (mem_resp) begin
                        if (DELAY == 0) begin
                            cpu_rdata <= mem_rdata;
                            cpu_resp  <= 1'b1;
                            state     <= S_RESP;
                        end else begin
                            rdata_q <= mem_rdata;
                            state   <= S_DELAY;
                        end
                    end else if (to_zero) begin
                        error[ERR_TIMEOUT] <= 1'b1;
                        state              <= S_IDLE;
                    end
                end
                S_DELAY: begin
                    if (dly_zero) begin
                        cpu_rdata <= rdata_q;
                        cpu_resp  <= 1'b1;
                        state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    cpu_resp <= 1'b0;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_latency_shim.sv
// Bench for mem_latency_shim: two instances (DELAY 0 and 3) share stimulus;
// a scoreboard predicts every memory request and CPU response cycle.
module tb_mem_latency_shim;

    localparam int TO = 8;
    localparam int NV = 5;

    typedef struct {
        int          dut;
        int          cyc;
        logic [31:0] addr;
        logic [3:0]  rm;
        logic [3:0]  wm;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  rm;
        logic [3:0]  wm;
        logic [31:0] wd;
        logic [31:0] rd;
        int          gap;
        logic [4:0]  err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cpu_addr, cpu_wdata, mem_rdata;
    logic [3:0]  cpu_rmask, cpu_wmask;
    logic        mem_resp;

    logic [31:0] cpu_rdata [2];
    logic        cpu_resp  [2];
    logic [31:0] mem_addr  [2];
    logic [3:0]  mem_rmask [2];
    logic [3:0]  mem_wmask [2];
    logic [31:0] mem_wdata [2];
    logic [4:0]  error     [2];

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t resp_q[$];
    exp_t req_q[$];
    vec_t vecs[NV];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_latency_shim #(.DELAY(0), .TIMEOUT(TO)) dut0 (
        .clk(clk), .rst(rst),
        .cpu_addr(cpu_addr), .cpu_rmask(cpu_rmask), .cpu_wmask(cpu_wmask), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata[0]), .cpu_resp(cpu_resp[0]),
        .mem_addr(mem_addr[0]), .mem_rmask(mem_rmask[0]), .mem_wmask(mem_wmask[0]), .mem_wdata(mem_wdata[0]),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp), .error(error[0])
    );

    mem_latency_shim #(.DELAY(3), .TIMEOUT(TO)) dut3 (
        .clk(clk), .rst(rst),
        .cpu_addr(cpu_addr), .cpu_rmask(cpu_rmask), .cpu_wmask(cpu_wmask), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata[1]), .cpu_resp(cpu_resp[1]),
        .mem_addr(mem_addr[1]), .mem_rmask(mem_rmask[1]), .mem_wmask(mem_wmask[1]), .mem_wdata(mem_wdata[1]),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp), .error(error[1])
    );

    function automatic int dly(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [31:0] a, input logic [3:0] rm, input logic [3:0] wm,
                       input logic [31:0] wd, input bit accept);
        cpu_addr  = a;
        cpu_rmask = rm;
        cpu_wmask = wm;
        cpu_wdata = wd;
        if (accept)
            for (int d = 0; d < 2; d++) req_q.push_back('{d, cyc + 1, a, rm, wm, wd});
        tick();
        cpu_rmask = '0;
        cpu_wmask = '0;
    endtask

    task automatic mresp(input logic [31:0] rd, input bit expect_resp);
        mem_resp  = 1'b1;
        mem_rdata = rd;
        if (expect_resp)
            for (int d = 0; d < 2; d++) resp_q.push_back('{d, cyc + 1 + dly(d), '0, '0, '0, rd});
        tick();
        mem_resp = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ticks(2);
        rst = 1'b0;
    endtask

    task automatic check_err(input string name, input logic [4:0] exp);
        for (int d = 0; d < 2; d++) check($sformatf("%s_dut%0d_error", name, d), error[d], exp);
    endtask

    task automatic check_drained(input string name);
        check({name, "_resp_pending"}, resp_q.size(), 0);
        check({name, "_req_pending"}, req_q.size(), 0);
    endtask

    // Scoreboard: every observed request/response must match the oldest expectation for its DUT.
    always @(negedge clk) begin : monitor
        int idx;
        if (!rst) begin
            for (int d = 0; d < 2; d++) begin
                if (cpu_resp[d]) begin
                    idx = -1;
                    foreach (resp_q[i]) if (idx < 0 && resp_q[i].dut == d) idx = i;
                    check($sformatf("dut%0d_resp_expected", d), idx >= 0, 1'b1);
                    if (idx >= 0) begin
                        check($sformatf("dut%0d_resp_cycle", d), cyc, resp_q[idx].cyc);
                        check($sformatf("dut%0d_resp_data", d), cpu_rdata[d], resp_q[idx].data);
                        resp_q.delete(idx);
                    end
                end
                if (mem_rmask[d] != '0 || mem_wmask[d] != '0) begin
                    idx = -1;
                    foreach (req_q[i]) if (idx < 0 && req_q[i].dut == d) idx = i;
                    check($sformatf("dut%0d_memreq_expected", d), idx >= 0, 1'b1);
                    if (idx >= 0) begin
                        check($sformatf("dut%0d_memreq_cycle", d), cyc, req_q[idx].cyc);
                        check($sformatf("dut%0d_memreq_addr", d), mem_addr[d], req_q[idx].addr);
                        check($sformatf("dut%0d_memreq_rmask", d), mem_rmask[d], req_q[idx].rm);
                        check($sformatf("dut%0d_memreq_wmask", d), mem_wmask[d], req_q[idx].wm);
                        check($sformatf("dut%0d_memreq_wdata", d), mem_wdata[d], req_q[idx].data);
                        req_q.delete(idx);
                    end
                end
            end
        end
    end

    initial begin
        vecs[0] = '{32'h0000_1000, 4'hF, 4'h0, 32'h0000_0000, 32'hDEAD_BEEF, 3, 5'b00000};
        vecs[1] = '{32'h0000_2004, 4'h0, 4'h3, 32'h0000_ABCD, 32'h1234_5678, 3, 5'b00000};
        vecs[2] = '{32'h0000_1002, 4'h1, 4'h1, 32'h55AA_55AA, 32'hCAFE_F00D, 2, 5'b00110};
        vecs[3] = '{32'h0000_3001, 4'h0, 4'hF, 32'h0BAD_CAFE, 32'hA5A5_0001, 9, 5'b00100};
        vecs[4] = '{32'h0000_4000, 4'h2, 4'h0, 32'h0000_0000, 32'h0F0F_F0F0, 5, 5'b00000};

        rst = 1'b1;
        cpu_addr = 32'hFFFF_FFFF; cpu_wdata = 32'hFFFF_FFFF;
        cpu_rmask = '0; cpu_wmask = '0;
        mem_rdata = '0; mem_resp = 1'b0;
        ticks(3);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_dut%0d_cpu_resp", d), cpu_resp[d], 1'b0);
            check($sformatf("rst_dut%0d_cpu_rdata", d), cpu_rdata[d], 32'h0);
            check($sformatf("rst_dut%0d_mem_addr", d), mem_addr[d], 32'h0);
            check($sformatf("rst_dut%0d_mem_wdata", d), mem_wdata[d], 32'h0);
            check($sformatf("rst_dut%0d_masks", d), {mem_rmask[d], mem_wmask[d]}, 8'h0);
        end
        check_err("rst", 5'b00000);
        rst = 1'b0;
        ticks(2);

        // Single transactions; gap 9 puts mem_resp in the final WAIT cycle.
        for (int v = 0; v < NV; v++) begin
            do_reset();
            req(vecs[v].addr, vecs[v].rm, vecs[v].wm, vecs[v].wd, 1'b1);
            ticks(vecs[v].gap - 1);
            mresp(vecs[v].rd, 1'b1);
            ticks(8);
            check_err($sformatf("vec%0d", v), vecs[v].err);
            for (int d = 0; d < 2; d++)
                check($sformatf("vec%0d_dut%0d_rdata_hold", v, d), cpu_rdata[d], vecs[v].rd);
            check_drained($sformatf("vec%0d", v));
        end

        // Second request while waiting on memory is dropped.
        do_reset();
        req(32'h0000_5000, 4'hF, 4'h0, 32'h0, 1'b1);
        tick();
        req(32'h0000_6000, 4'hF, 4'h0, 32'h0, 1'b0);
        mresp(32'h1111_2222, 1'b1);
        ticks(8);
        check_err("overlap_wait", 5'b00001);
        check_drained("overlap_wait");

        // Request in the same cycle as the DELAY=0 response is also overlap.
        do_reset();
        req(32'h0000_7000, 4'hF, 4'h0, 32'h0, 1'b1);
        tick();
        mresp(32'h3333_4444, 1'b1);
        req(32'h0000_7004, 4'hF, 4'h0, 32'h0, 1'b0);
        ticks(8);
        check_err("overlap_resp", 5'b00001);
        check_drained("overlap_resp");

        // Silent memory: error[3] exactly TO cycles after WAIT begins, then recovery.
        do_reset();
        req(32'h0000_8000, 4'hF, 4'h0, 32'h0, 1'b1);
        ticks(8);
        check_err("timeout_before", 5'b00000);
        tick();
        check_err("timeout_at", 5'b01000);
        req(32'h0000_8004, 4'hF, 4'h0, 32'h0, 1'b1);
        tick();
        mresp(32'h5555_6666, 1'b1);
        ticks(8);
        check_err("timeout_after", 5'b01000);
        check_drained("timeout");

        // Reset in WAIT abandons the transaction; the late mem_resp is spurious.
        do_reset();
        req(32'h0000_9000, 4'hF, 4'h0, 32'h0, 1'b1);
        tick();
        do_reset();
        tick();
        check_err("rst_mid_clean", 5'b00000);
        mresp(32'h7777_8888, 1'b0);
        ticks(8);
        check_err("rst_mid_spurious", 5'b10000);
        check_drained("rst_mid");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
